// File: rtl/mem_arb_pkg.sv
// Shared types and sizes for the two-port (optionally three-port) RAM arbiter.
// Optional debug port is enabled with the MEM_ARB_DBG_EN macro.
package mem_arb_pkg;

    localparam int unsigned ADDR_W       = 8;
    localparam int unsigned DATA_W       = 16;
    localparam int unsigned STARVE_LIMIT = 3;
    localparam int unsigned STARVE_W     = 2;

    // Command presented to the single-port RAM
    typedef enum logic [1:0] {
        NONE  = 2'b00,
        READ  = 2'b01,
        WRITE = 2'b10
    } mem_cmd_e;

    // Arbiter sequencing state
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        RESP  = 2'b10
    } arb_state_e;

    // Requester identity of the captured winner
    typedef enum logic [1:0] {
        REQ_IF  = 2'b00,
        REQ_LS  = 2'b01,
        REQ_DBG = 2'b10
    } req_id_e;

    // Transfer captured at arbitration and replayed to the RAM in ISSUE
    typedef struct packed {
        req_id_e             id;
        logic                we;
        logic [ADDR_W-1:0]   addr;
        logic [DATA_W-1:0]   wdata;
    } xfer_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection: debug (optional) > fetch-when-starved > load/store > fetch.
// Debug requester exists only when MEM_ARB_DBG_EN is defined.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic    if_req_i,
    input  logic    ls_req_i,
`ifdef MEM_ARB_DBG_EN
    input  logic    dbg_req_i,
`endif
    input  logic    starve_hit_i,
    output logic    win_valid_c_o,
    output req_id_e win_id_c_o
);

    // Fixed priority with the starvation override for fetch
    always_comb begin
        win_valid_c_o = 1'b0;
        win_id_c_o    = REQ_IF;
`ifdef MEM_ARB_DBG_EN
        if (dbg_req_i) begin
            win_valid_c_o = 1'b1;
            win_id_c_o    = REQ_DBG;
        end else
`endif
        if (if_req_i && starve_hit_i) begin
            win_valid_c_o = 1'b1;
            win_id_c_o    = REQ_IF;
        end else if (ls_req_i) begin
            win_valid_c_o = 1'b1;
            win_id_c_o    = REQ_LS;
        end else if (if_req_i) begin
            win_valid_c_o = 1'b1;
            win_id_c_o    = REQ_IF;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one 256x16 synchronous RAM between fetch and load/store requesters.
// IDLE -> ISSUE -> (RESP for reads) with back-to-back re-arbitration.
// Defining MEM_ARB_DBG_EN adds a highest-priority debug port.
module mem_arbiter
    import mem_arb_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_gnt,
    output logic              ls_rvalid,
    output logic [DATA_W-1:0] ls_rdata,
    output logic [1:0]        mem_cmd,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
`ifdef MEM_ARB_DBG_EN
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
`endif
    output logic              busy
);

    arb_state_e            state_q, state_d;
    xfer_t                 xfer_q, xfer_d;
    logic [STARVE_W-1:0]   starve_q, starve_d;

    logic    win_valid_c;
    req_id_e win_id_c;
    xfer_t   cand_c;
    logic    arb_pt_c;
    logic    starve_hit_c;

    assign starve_hit_c = (starve_q == STARVE_W'(STARVE_LIMIT));

    mem_arb_pick u_pick (
        .if_req_i      (if_req),
        .ls_req_i      (ls_req),
`ifdef MEM_ARB_DBG_EN
        .dbg_req_i     (dbg_req),
`endif
        .starve_hit_i  (starve_hit_c),
        .win_valid_c_o (win_valid_c),
        .win_id_c_o    (win_id_c)
    );

    // Candidate transfer taken from whichever requester the picker selected
    always_comb begin
        cand_c    = '0;
        cand_c.id = win_id_c;
        case (win_id_c)
            REQ_LS: begin
                cand_c.we    = ls_we;
                cand_c.addr  = ls_addr;
                cand_c.wdata = ls_wdata;
            end
`ifdef MEM_ARB_DBG_EN
            REQ_DBG: begin
                cand_c.we    = dbg_we;
                cand_c.addr  = dbg_addr;
                cand_c.wdata = dbg_wdata;
            end
`endif
            default: begin
                cand_c.we   = 1'b0;
                cand_c.addr = if_addr;
            end
        endcase
    end

    // Next state: arbitrate at the end of IDLE, a write ISSUE, or RESP
    always_comb begin
        state_d  = state_q;
        xfer_d   = xfer_q;
        starve_d = starve_q;
        arb_pt_c = 1'b0;
        case (state_q)
            IDLE:  arb_pt_c = 1'b1;
            ISSUE: begin
                if (xfer_q.we) arb_pt_c = 1'b1;
                else           state_d  = RESP;
            end
            RESP:  arb_pt_c = 1'b1;
            default: state_d = IDLE;
        endcase
        if (arb_pt_c) begin
            if (win_valid_c) begin
                state_d = ISSUE;
                xfer_d  = cand_c;
            end else begin
                state_d = IDLE;
            end
            // Count only arbitrations that leave a pending fetch waiting
            if (!if_req || (win_valid_c && (win_id_c == REQ_IF))) begin
                starve_d = '0;
            end else if (!starve_hit_c) begin
                starve_d = starve_q + STARVE_W'(1);
            end
        end
    end

    // State, captured transfer and starvation counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            xfer_q   <= '0;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            xfer_q   <= xfer_d;
            starve_q <= starve_d;
        end
    end

    // Outputs decoded from the state register; read data passes through in RESP only
    always_comb begin
        busy      = (state_q != IDLE);
        mem_cmd   = NONE;
        mem_addr  = '0;
        mem_wdata = '0;
        if_gnt    = 1'b0;
        ls_gnt    = 1'b0;
        if_rvalid = 1'b0;
        ls_rvalid = 1'b0;
        if_rdata  = '0;
        ls_rdata  = '0;
`ifdef MEM_ARB_DBG_EN
        dbg_gnt    = 1'b0;
        dbg_rvalid = 1'b0;
        dbg_rdata  = '0;
`endif
        if (state_q == ISSUE) begin
            mem_cmd   = xfer_q.we ? WRITE : READ;
            mem_addr  = xfer_q.addr;
            mem_wdata = xfer_q.wdata;
            if_gnt    = (xfer_q.id == REQ_IF);
            ls_gnt    = (xfer_q.id == REQ_LS);
`ifdef MEM_ARB_DBG_EN
            dbg_gnt   = (xfer_q.id == REQ_DBG);
`endif
        end
        if (state_q == RESP) begin
            if_rvalid = (xfer_q.id == REQ_IF);
            ls_rvalid = (xfer_q.id == REQ_LS);
            if (if_rvalid) if_rdata = mem_rdata;
            if (ls_rvalid) ls_rdata = mem_rdata;
`ifdef MEM_ARB_DBG_EN
            dbg_rvalid = (xfer_q.id == REQ_DBG);
            if (dbg_rvalid) dbg_rdata = mem_rdata;
`endif
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural 256x16 synchronous RAM.
// Inputs change and outputs are checked on the falling clock edge.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [7:0]  if_addr;
    logic        if_gnt, if_rvalid;
    logic [15:0] if_rdata;
    logic        ls_req, ls_we;
    logic [7:0]  ls_addr;
    logic [15:0] ls_wdata;
    logic        ls_gnt, ls_rvalid;
    logic [15:0] ls_rdata;
    logic [1:0]  mem_cmd;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        busy;
`ifdef MEM_ARB_DBG_EN
    logic        dbg_req, dbg_we;
    logic [7:0]  dbg_addr;
    logic [15:0] dbg_wdata;
    logic        dbg_gnt, dbg_rvalid;
    logic [15:0] dbg_rdata;
`endif

    logic [15:0] ram [256];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .ls_req    (ls_req),
        .ls_we     (ls_we),
        .ls_addr   (ls_addr),
        .ls_wdata  (ls_wdata),
        .ls_gnt    (ls_gnt),
        .ls_rvalid (ls_rvalid),
        .ls_rdata  (ls_rdata),
        .mem_cmd   (mem_cmd),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
`ifdef MEM_ARB_DBG_EN
        .dbg_req    (dbg_req),
        .dbg_we     (dbg_we),
        .dbg_addr   (dbg_addr),
        .dbg_wdata  (dbg_wdata),
        .dbg_gnt    (dbg_gnt),
        .dbg_rvalid (dbg_rvalid),
        .dbg_rdata  (dbg_rdata),
`endif
        .busy      (busy)
    );

    // RAM model: write commits at the edge, read data valid the following cycle
    always @(posedge clk) begin
        if (mem_cmd == 2'b10) ram[mem_addr] <= mem_wdata;
        if (mem_cmd == 2'b01) mem_rdata <= ram[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 16'h0000;
        ram[8'h10] = 16'hABCD;
        ram[8'h11] = 16'h5511;
        ram[8'h30] = 16'h3030;
        ram[8'h05] = 16'h0505;
        ram[8'h06] = 16'h0606;
        ram[8'h00] = 16'hA000;
        ram[8'h01] = 16'hA001;
        ram[8'h02] = 16'hA002;
        mem_rdata = 16'h0;
        reset = 1'b1;
        if_req = 1'b0; if_addr = 8'h0;
        ls_req = 1'b0; ls_we = 1'b0; ls_addr = 8'h0; ls_wdata = 16'h0;
`ifdef MEM_ARB_DBG_EN
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = 8'h0; dbg_wdata = 16'h0;
`endif

        // Reset state
        step(); step();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cmd", 32'(mem_cmd), 32'd0);
        check("rst_gnt", 32'({if_gnt, ls_gnt}), 32'd0);
        check("rst_rvalid", 32'({if_rvalid, ls_rvalid}), 32'd0);
        check("rst_rdata", 32'({if_rdata, ls_rdata}), 32'd0);
        reset = 1'b0;
        step();

        // Lone fetch read
        if_req = 1'b1; if_addr = 8'h10;
        step();
        check("f_gnt", 32'(if_gnt), 32'd1);
        check("f_cmd", 32'(mem_cmd), 32'd1);
        check("f_addr", 32'(mem_addr), 32'h10);
        check("f_busy", 32'(busy), 32'd1);
        check("f_lsgnt", 32'(ls_gnt), 32'd0);
        if_req = 1'b0;
        step();
        check("f_rvalid", 32'(if_rvalid), 32'd1);
        check("f_rdata", 32'(if_rdata), 32'hABCD);
        check("f_resp_cmd", 32'(mem_cmd), 32'd0);
        check("f_ls_rvalid", 32'(ls_rvalid), 32'd0);
        step();
        check("f_idle_busy", 32'(busy), 32'd0);
        check("f_idle_rdata", 32'(if_rdata), 32'd0);

        // Simultaneous requests: load/store write first, fetch right after
        if_req = 1'b1; if_addr = 8'h11;
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 8'h20; ls_wdata = 16'h1234;
        step();
        check("sim_lsgnt", 32'({ls_gnt, if_gnt}), 32'b10);
        check("sim_cmd", 32'(mem_cmd), 32'd2);
        check("sim_addr", 32'(mem_addr), 32'h20);
        check("sim_wdata", 32'(mem_wdata), 32'h1234);
        ls_req = 1'b0;
        step();
        check("sim_ifgnt", 32'({ls_gnt, if_gnt}), 32'b01);
        check("sim_if_addr", 32'(mem_addr), 32'h11);
        check("sim_written", 32'(ram[8'h20]), 32'h1234);
        if_req = 1'b0;
        step();
        check("sim_rdata", 32'(if_rdata), 32'h5511);
        step();
        check("sim_idle", 32'(busy), 32'd0);

        // Starvation: three load/store writes, then forced fetch, then the fourth write
        if_req = 1'b1; if_addr = 8'h30;
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 8'h40; ls_wdata = 16'd1;
        for (int i = 1; i <= 3; i++) begin
            step();
            check("stv_lsgnt", 32'({ls_gnt, if_gnt}), 32'b10);
            check("stv_wdata", 32'(mem_wdata), 32'(i));
            ls_wdata = 16'(i + 1);
        end
        step();
        check("stv_ifgnt", 32'({ls_gnt, if_gnt}), 32'b01);
        check("stv_if_addr", 32'(mem_addr), 32'h30);
        check("stv_cnt0", 32'(dut.starve_q), 32'd0);
        if_req = 1'b0;
        step();
        check("stv_rdata", 32'({if_rvalid, if_rdata}), 32'h1_3030);
        step();
        check("stv_4th_gnt", 32'(ls_gnt), 32'd1);
        check("stv_4th_wdata", 32'(mem_wdata), 32'd4);
        ls_req = 1'b0;
        step();
        check("stv_ram", 32'(ram[8'h40]), 32'd4);
        check("stv_idle", 32'(busy), 32'd0);

        // Reset during RESP of a load aborts the response
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 8'h05;
        step();
        check("rr_gnt", 32'(ls_gnt), 32'd1);
        ls_req = 1'b0;
        step();
        check("rr_resp", 32'(busy), 32'd1);
        reset = 1'b1;
        step();
        check("rr_rvalid", 32'(ls_rvalid), 32'd0);
        check("rr_cmd", 32'(mem_cmd), 32'd0);
        check("rr_busy", 32'(busy), 32'd0);
        reset = 1'b0;

        // Reset during ISSUE of a load: no response follows
        ls_req = 1'b1; ls_addr = 8'h06;
        step();
        check("ri_gnt", 32'(ls_gnt), 32'd1);
        ls_req = 1'b0; reset = 1'b1;
        step();
        check("ri_rvalid", 32'(ls_rvalid), 32'd0);
        check("ri_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        step();

        // Back-to-back reads: one read every two cycles while ls_req stays high
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 8'h00;
        for (int i = 0; i < 3; i++) begin
            step();
            check("b2b_gnt", 32'({ls_gnt, ls_rvalid}), 32'b10);
            check("b2b_addr", 32'(mem_addr), 32'(i));
            if (i == 2) ls_req = 1'b0;
            else        ls_addr = 8'(i + 1);
            step();
            check("b2b_rvalid", 32'({ls_gnt, ls_rvalid}), 32'b01);
            check("b2b_rdata", 32'(ls_rdata), 32'hA000 + 32'(i));
        end
        step();
        check("b2b_idle", 32'(busy), 32'd0);

`ifdef MEM_ARB_DBG_EN
        // Debug beats load/store, which beats fetch
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 8'h50; dbg_wdata = 16'hD00D;
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 8'h51; ls_wdata = 16'h5151;
        if_req = 1'b1; if_addr = 8'h10;
        step();
        check("dbg_first", 32'({dbg_gnt, ls_gnt, if_gnt}), 32'b100);
        dbg_req = 1'b0;
        step();
        check("dbg_second", 32'({dbg_gnt, ls_gnt, if_gnt}), 32'b010);
        ls_req = 1'b0;
        step();
        check("dbg_third", 32'({dbg_gnt, ls_gnt, if_gnt}), 32'b001);
        if_req = 1'b0;
        step();
        check("dbg_ram", 32'(ram[8'h50]), 32'hD00D);
        step();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
